// File: rtl/check_char_pkg.sv
// Shared types and constants for the RC4 key-search character checker.
// Optional feature macro: CHECK_CHAR_UPPER_EN (see char_validator).
package check_char_pkg;

    localparam int unsigned KEY_W = 24;

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_LOW_A = 8'd97;
    localparam logic [7:0] ASCII_LOW_Z = 8'd122;
    localparam logic [7:0] ASCII_UP_A  = 8'd65;
    localparam logic [7:0] ASCII_UP_Z  = 8'd90;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CHECK,
        ST_ACCEPT,
        ST_REJECT,
        ST_FOUND,
        ST_FAIL
    } check_state_t;

endpackage

// File: rtl/char_validator.sv
// Combinational plaintext-character classifier: space and a-z are valid.
// With CHECK_CHAR_UPPER_EN defined, A-Z is valid as well.
module char_validator
    import check_char_pkg::*;
(
    input  logic [KEY_W-1:0] char_in,
    output logic             valid
);

    logic [7:0] ch;
    logic       hi_zero;
    logic       is_lower;
    logic       is_upper;

    always_comb begin
        ch       = char_in[7:0];
        hi_zero  = (char_in[KEY_W-1:8] == '0);
        is_lower = (ch >= ASCII_LOW_A) && (ch <= ASCII_LOW_Z);
`ifdef CHECK_CHAR_UPPER_EN
        is_upper = (ch >= ASCII_UP_A) && (ch <= ASCII_UP_Z);
`else
        is_upper = 1'b0;
`endif
        valid    = hi_zero && ((ch == ASCII_SPACE) || is_lower || is_upper);
    end

endmodule

// File: rtl/check_char_unit.sv
// Key-search checker: judges each decrypted character, advances or rejects
// the 24-bit key, and reports found / exhausted. Macro: CHECK_CHAR_UPPER_EN.
module check_char_unit
    import check_char_pkg::*;
#(
    parameter int unsigned      MSG_LEN = 32,
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
) (
    input  logic             clok,
    input  logic             resetm,
    input  logic             new_char,
    input  logic [KEY_W-1:0] char_recieved,
    input  logic [5:0]       char_count,
    output logic             compared_char,
    output logic             matched_cont,
    output logic             new_key,
    output logic             start_over,
    output logic             found_key,
    output logic             last_key,
    output logic             done,
    output logic [KEY_W-1:0] key,
    output logic [1:0]       LEDS
);

    localparam logic [5:0] LAST_IDX = 6'(MSG_LEN - 1);

    check_state_t     state_q, state_d;
    logic [KEY_W-1:0] char_q, char_d;
    logic [5:0]       count_q, count_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             compared_q, compared_d;
    logic             matched_q, matched_d;
    logic             new_key_q, new_key_d;
    logic             start_over_q, start_over_d;
    logic             found_q, found_d;
    logic             last_q, last_d;
    logic             char_valid;

    char_validator u_validator (
        .char_in (char_q),
        .valid   (char_valid)
    );

    always_comb begin
        state_d      = state_q;
        char_d       = char_q;
        count_d      = count_q;
        key_d        = key_q;
        compared_d   = 1'b0;
        matched_d    = 1'b0;
        new_key_d    = 1'b0;
        start_over_d = 1'b0;
        found_d      = found_q;
        last_d       = last_q;

        case (state_q)
            ST_WAIT: begin
                // A character presented during the pulse cycle is ignored.
                if (new_char && !compared_q) begin
                    char_d  = char_recieved;
                    count_d = char_count;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (char_valid) begin
                    state_d = (count_q == LAST_IDX) ? ST_FOUND : ST_ACCEPT;
                end else begin
                    state_d = (key_q == KEY_MAX) ? ST_FAIL : ST_REJECT;
                end
            end
            ST_ACCEPT: begin
                compared_d = 1'b1;
                matched_d  = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_REJECT: begin
                key_d        = key_q + 1'b1;
                compared_d   = 1'b1;
                new_key_d    = 1'b1;
                start_over_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_FOUND: begin
                compared_d = !found_q;
                found_d    = 1'b1;
            end
            ST_FAIL: begin
                compared_d = !last_q;
                last_d     = 1'b1;
                key_d      = KEY_MAX;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clok) begin
        if (resetm) begin
            state_q      <= ST_WAIT;
            char_q       <= '0;
            count_q      <= '0;
            key_q        <= '0;
            compared_q   <= 1'b0;
            matched_q    <= 1'b0;
            new_key_q    <= 1'b0;
            start_over_q <= 1'b0;
            found_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            char_q       <= char_d;
            count_q      <= count_d;
            key_q        <= key_d;
            compared_q   <= compared_d;
            matched_q    <= matched_d;
            new_key_q    <= new_key_d;
            start_over_q <= start_over_d;
            found_q      <= found_d;
            last_q       <= last_d;
        end
    end

    assign compared_char = compared_q;
    assign matched_cont  = matched_q;
    assign new_key       = new_key_q;
    assign start_over    = start_over_q;
    assign found_key     = found_q;
    assign last_key      = last_q;
    assign done          = found_q | last_q;
    assign key           = key_q;
    assign LEDS          = {last_q, found_q};

endmodule

// File: tb/tb_check_char_unit.sv
// Scoreboard bench for check_char_unit: driver pushes expected outcomes from a
// rule-level model, a negedge monitor pops them on every compared_char pulse.
module tb_check_char_unit;

    localparam logic [23:0] KMAX = 24'd3;
    localparam int unsigned MLEN = 32;

    logic        clok = 1'b0;
    logic        resetm;
    logic        new_char;
    logic [23:0] char_recieved;
    logic [5:0]  char_count;
    logic        compared_char, matched_cont, new_key, start_over;
    logic        found_key, last_key, done;
    logic [23:0] key;
    logic [1:0]  LEDS;

    always #5 clok = ~clok;

    check_char_unit #(.MSG_LEN(MLEN), .KEY_MAX(KMAX)) dut (
        .clok          (clok),
        .resetm        (resetm),
        .new_char      (new_char),
        .char_recieved (char_recieved),
        .char_count    (char_count),
        .compared_char (compared_char),
        .matched_cont  (matched_cont),
        .new_key       (new_key),
        .start_over    (start_over),
        .found_key     (found_key),
        .last_key      (last_key),
        .done          (done),
        .key           (key),
        .LEDS          (LEDS)
    );

    typedef struct {
        bit          matched;
        bit          rejected;
        logic [23:0] key;
        bit          found;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [23:0] m_key;
    bit          m_found, m_last;

    function automatic bit ref_valid(input logic [23:0] c);
        if (c > 24'd255) return 1'b0;
        if (c == 24'd32) return 1'b1;
        if (c >= 24'd97 && c <= 24'd122) return 1'b1;
`ifdef CHECK_CHAR_UPPER_EN
        if (c >= 24'd65 && c <= 24'd90) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clok) begin
        if (resetm === 1'b0) begin
            if (compared_char === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_compared_char", 32'(compared_char), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("matched_cont", 32'(matched_cont), 32'(e.matched));
                    chk("new_key",      32'(new_key),      32'(e.rejected));
                    chk("start_over",   32'(start_over),   32'(e.rejected));
                    chk("key",          32'(key),          32'(e.key));
                    chk("found_key",    32'(found_key),    32'(e.found));
                    chk("last_key",     32'(last_key),     32'(e.last));
                    chk("done",         32'(done),         32'(e.found | e.last));
                    chk("LEDS",         32'(LEDS),         32'({e.last, e.found}));
                end
            end else if (matched_cont !== 1'b0 || new_key !== 1'b0 || start_over !== 1'b0) begin
                chk("stray_pulse", 32'({matched_cont, new_key, start_over}), 32'd0);
            end
        end
    end

    task automatic do_reset();
        resetm        = 1'b1;
        new_char      = 1'b0;
        char_recieved = '0;
        char_count    = '0;
        repeat (2) @(negedge clok);
        sb.delete();
        m_key   = '0;
        m_found = 1'b0;
        m_last  = 1'b0;
        chk("rst_outputs",
            32'({compared_char, matched_cont, new_key, start_over, found_key, last_key, done, LEDS}),
            32'd0);
        chk("rst_key", 32'(key), 32'd0);
        resetm = 1'b0;
    endtask

    task automatic send(input logic [23:0] c, input logic [5:0] cnt);
        bit   expect_pulse;
        bit   seen;
        exp_t e;
        expect_pulse = !(m_found || m_last);
        if (expect_pulse) begin
            e.matched  = 1'b0;
            e.rejected = 1'b0;
            if (ref_valid(c)) begin
                if (int'(cnt) == MLEN - 1) m_found = 1'b1;
                else e.matched = 1'b1;
            end else if (m_key == KMAX) begin
                m_last = 1'b1;
            end else begin
                m_key      = m_key + 24'd1;
                e.rejected = 1'b1;
            end
            e.key   = m_key;
            e.found = m_found;
            e.last  = m_last;
            sb.push_back(e);
        end
        @(negedge clok);
        new_char      = 1'b1;
        char_recieved = c;
        char_count    = cnt;
        @(negedge clok);
        new_char = 1'b0;
        if (expect_pulse) begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clok);
                if (compared_char === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                chk("pulse_timeout", 32'd0, 32'd1);
                if (sb.size() > 0) void'(sb.pop_back());
            end
            @(negedge clok);
        end else begin
            repeat (5) @(negedge clok);
        end
    endtask

    initial begin
        logic [23:0] c;
        logic [5:0]  cnt;

        // Accept, reject, then complete message; later characters are ignored.
        do_reset();
        send(24'd99, 6'd5);
        send(24'd50, 6'd3);
        send(24'd32, 6'd31);
        send(24'd99, 6'd1);
        send(24'd50, 6'd2);
        chk("found_sticky_key",  32'(key),  32'd1);
        chk("found_sticky_leds", 32'(LEDS), 32'b01);
        chk("found_sticky_done", 32'(done), 32'd1);

        // Walk the key up to KMAX, then exhaust.
        do_reset();
        repeat (4) send(24'd50, 6'd0);
        send(24'd50, 6'd0);
        chk("fail_sticky_key",  32'(key),  32'(KMAX));
        chk("fail_sticky_leds", 32'(LEDS), 32'b10);

        // Reset pulled while in a sticky state.
        do_reset();
        send(24'd65, 6'd0);
        send(24'h000161, 6'd4);

        // Randomised characters, counts and keys.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(3))
                0: c = 24'd97 + 24'($urandom_range(25));
                1: c = 24'd32;
                2: c = 24'($urandom_range(255));
                default: c = 24'($urandom) | 24'h000100;
            endcase
            cnt = ($urandom_range(7) == 0) ? 6'd31 : 6'($urandom_range(31));
            send(c, cnt);
            if (m_found || m_last) begin
                if ($urandom_range(1) == 1) send(24'd97, 6'd31);
                do_reset();
            end
        end

        repeat (3) @(negedge clok);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
